// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo datapath constants: tag/data widths, functional-unit count,
// and the helper that advances a round-robin index.
package tomasulo_pkg;

  localparam int TAGW     = 3;
  localparam int DATAW    = 16;
  localparam int RDW      = 3;
  localparam int NFU      = 3;
  localparam int TAG_NONE = 0;

  typedef logic [1:0] fu_idx_t;

  function automatic fu_idx_t next_fu(input fu_idx_t idx);
    return (idx == fu_idx_t'(NFU - 1)) ? fu_idx_t'(0) : idx + fu_idx_t'(1);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Rotating-priority picker: the first eligible requester at or after ptr
// (wrapping mod NFU) wins.
module rr_picker
  import tomasulo_pkg::*;
(
  input  logic [NFU-1:0] eligible,
  input  fu_idx_t        ptr,
  output logic [NFU-1:0] onehot,
  output fu_idx_t        idx
);

  logic    found;
  fu_idx_t cand;

  // NOTE: every variable written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    onehot = '0;
    idx    = ptr;
    found  = 1'b0;
    cand   = ptr;
    for (int k = 0; k < NFU; k++) begin
      if (!found && eligible[cand]) begin
        found        = 1'b1;
        idx          = cand;
        onehot[cand] = 1'b1;
      end
      cand = next_fu(cand);
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: grants one functional unit per cycle round-robin,
// registers its result onto the bus and drives the register-file write port.
module cdb_arbiter
  import tomasulo_pkg::NFU, tomasulo_pkg::RDW, tomasulo_pkg::TAG_NONE,
         tomasulo_pkg::fu_idx_t, tomasulo_pkg::next_fu;
#(
  parameter int TAGW  = tomasulo_pkg::TAGW,
  parameter int DATAW = tomasulo_pkg::DATAW
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic [NFU-1:0]   req,
  input  logic [TAGW-1:0]  tag0,
  input  logic [TAGW-1:0]  tag1,
  input  logic [TAGW-1:0]  tag2,
  input  logic [RDW-1:0]   rd0,
  input  logic [RDW-1:0]   rd1,
  input  logic [RDW-1:0]   rd2,
  input  logic [DATAW-1:0] data0,
  input  logic [DATAW-1:0] data1,
  input  logic [DATAW-1:0] data2,
  input  logic             cdbStall,
  output logic [NFU-1:0]   gnt,
  output logic             cdbValid,
  output logic [TAGW-1:0]  cdbTag,
  output logic [DATAW-1:0] cdbData,
  output logic [RDW-1:0]   cdbRd,
  output logic             rfWren,
  output logic [RDW-1:0]   rfNumW,
  output logic [TAGW-1:0]  rfDepW,
  output logic [DATAW-1:0] rfDataW
);

  fu_idx_t          ptr_q, ptr_d;
  logic [NFU-1:0]   gnt_q, gnt_d;
  logic             valid_q, valid_d;
  logic [TAGW-1:0]  tag_q, tag_d;
  logic [DATAW-1:0] data_q, data_d;
  logic [RDW-1:0]   rd_q, rd_d;

  logic [NFU-1:0]   eligible, win_onehot;
  fu_idx_t          win_idx;
  logic [TAGW-1:0]  win_tag;
  logic [DATAW-1:0] win_data;
  logic [RDW-1:0]   win_rd;

  // The unit granted this cycle is still holding req; masking it stops a
  // double grant before it has seen gnt.
  assign eligible = req & ~gnt_q;

  rr_picker u_picker (
    .eligible (eligible),
    .ptr      (ptr_q),
    .onehot   (win_onehot),
    .idx      (win_idx)
  );

  always_comb begin
    case (win_idx)
      fu_idx_t'(1): begin win_tag = tag1; win_data = data1; win_rd = rd1; end
      fu_idx_t'(2): begin win_tag = tag2; win_data = data2; win_rd = rd2; end
      default:      begin win_tag = tag0; win_data = data0; win_rd = rd0; end
    endcase
  end

  always_comb begin
    ptr_d   = ptr_q;
    gnt_d   = '0;
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    rd_d    = rd_q;
    if (!cdbStall) begin
      if (|eligible) begin
        gnt_d   = win_onehot;
        valid_d = 1'b1;
        tag_d   = win_tag;
        data_d  = win_data;
        rd_d    = win_rd;
        ptr_d   = next_fu(win_idx);
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value regardless of statement order.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      ptr_q   <= '0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
      rd_q    <= '0;
    end else begin
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      rd_q    <= rd_d;
    end
  end

  assign gnt      = gnt_q;
  assign cdbValid = valid_q;
  assign cdbTag   = tag_q;
  assign cdbData  = data_q;
  assign cdbRd    = rd_q;

  // A broadcast is consumed only in a cycle where the bus is not stalled.
  assign rfWren  = valid_q & ~cdbStall;
  assign rfNumW  = rd_q;
  assign rfDataW = data_q;
  assign rfDepW  = TAGW'(TAG_NONE);

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus randomized
// traffic compared against a behavioural bus model.
module tb_cdb_arbiter;

  logic        CLK;
  logic        CLR;
  logic [2:0]  req;
  logic [2:0]  tag0, tag1, tag2;
  logic [2:0]  rd0, rd1, rd2;
  logic [15:0] data0, data1, data2;
  logic        cdbStall;
  logic [2:0]  gnt;
  logic        cdbValid;
  logic [2:0]  cdbTag;
  logic [15:0] cdbData;
  logic [2:0]  cdbRd;
  logic        rfWren;
  logic [2:0]  rfNumW;
  logic [2:0]  rfDepW;
  logic [15:0] rfDataW;

  int n_checks = 0;
  int n_fails  = 0;

  // Behavioural model of what the bus should show after each edge.
  int          m_ptr;
  logic [2:0]  m_gnt;
  logic        m_valid;
  logic [2:0]  m_tag;
  logic [15:0] m_data;
  logic [2:0]  m_rd;

  cdb_arbiter #(.TAGW(3), .DATAW(16)) dut (
    .CLK      (CLK),
    .CLR      (CLR),
    .req      (req),
    .tag0     (tag0),
    .tag1     (tag1),
    .tag2     (tag2),
    .rd0      (rd0),
    .rd1      (rd1),
    .rd2      (rd2),
    .data0    (data0),
    .data1    (data1),
    .data2    (data2),
    .cdbStall (cdbStall),
    .gnt      (gnt),
    .cdbValid (cdbValid),
    .cdbTag   (cdbTag),
    .cdbData  (cdbData),
    .cdbRd    (cdbRd),
    .rfWren   (rfWren),
    .rfNumW   (rfNumW),
    .rfDepW   (rfDepW),
    .rfDataW  (rfDataW)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic model_update();
    logic [2:0]  t [3];
    logic [2:0]  r [3];
    logic [15:0] d [3];
    int w;
    t[0] = tag0;  t[1] = tag1;  t[2] = tag2;
    r[0] = rd0;   r[1] = rd1;   r[2] = rd2;
    d[0] = data0; d[1] = data1; d[2] = data2;
    if (CLR) begin
      m_ptr = 0; m_gnt = 3'b000; m_valid = 1'b0;
      m_tag = 3'd0; m_data = 16'd0; m_rd = 3'd0;
    end else if (cdbStall) begin
      m_gnt = 3'b000;
    end else begin
      w = -1;
      for (int k = 0; k < 3; k++) begin
        int f;
        f = (m_ptr + k) % 3;
        if (w < 0 && req[f] && !m_gnt[f]) w = f;
      end
      if (w >= 0) begin
        m_tag   = t[w];
        m_rd    = r[w];
        m_data  = d[w];
        m_valid = 1'b1;
        m_gnt   = 3'b001 << w;
        m_ptr   = (w + 1) % 3;
      end else begin
        m_valid = 1'b0;
        m_gnt   = 3'b000;
      end
    end
  endtask

  // Advance one edge, keep the model in step, and settle past the edge.
  task automatic tick();
    @(posedge CLK);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
  endtask

  task automatic test_reset();
    CLR = 1'b1; cdbStall = 1'b1; req = 3'b111;
    tick();
    CLR = 1'b0; cdbStall = 1'b0; req = 3'b000;
    #1;
    n_checks++; if (gnt !== 3'b000) begin n_fails++; $display("FAIL reset_gnt: got %b want 000", gnt); end
    n_checks++; if (cdbValid !== 1'b0) begin n_fails++; $display("FAIL reset_valid: got %b want 0", cdbValid); end
    n_checks++; if (cdbTag !== 3'd0) begin n_fails++; $display("FAIL reset_tag: got %0d want 0", cdbTag); end
    n_checks++; if (cdbData !== 16'd0) begin n_fails++; $display("FAIL reset_data: got %h want 0000", cdbData); end
    n_checks++; if (cdbRd !== 3'd0) begin n_fails++; $display("FAIL reset_rd: got %0d want 0", cdbRd); end
    n_checks++; if (rfWren !== 1'b0) begin n_fails++; $display("FAIL reset_rfwren: got %b want 0", rfWren); end
  endtask

  task automatic test_single();
    req = 3'b001; tag0 = 3'd3; rd0 = 3'd5; data0 = 16'h1234;
    tick();
    n_checks++; if (gnt !== 3'b001) begin n_fails++; $display("FAIL single_gnt: got %b want 001", gnt); end
    n_checks++; if (cdbValid !== 1'b1) begin n_fails++; $display("FAIL single_valid: got %b want 1", cdbValid); end
    n_checks++; if (cdbTag !== 3'd3) begin n_fails++; $display("FAIL single_tag: got %0d want 3", cdbTag); end
    n_checks++; if (rfWren !== 1'b1) begin n_fails++; $display("FAIL single_rfwren: got %b want 1", rfWren); end
    n_checks++; if (rfNumW !== 3'd5) begin n_fails++; $display("FAIL single_rfnumw: got %0d want 5", rfNumW); end
    n_checks++; if (rfDataW !== 16'h1234) begin n_fails++; $display("FAIL single_rfdataw: got %h want 1234", rfDataW); end
    n_checks++; if (rfDepW !== 3'd0) begin n_fails++; $display("FAIL single_rfdepw: got %0d want 0", rfDepW); end
    req = 3'b000;
  endtask

  task automatic test_idle_gap();
    req = 3'b000;
    tick();
    n_checks++; if (cdbValid !== 1'b0) begin n_fails++; $display("FAIL idle_valid: got %b want 0", cdbValid); end
    n_checks++; if (rfWren !== 1'b0) begin n_fails++; $display("FAIL idle_rfwren: got %b want 0", rfWren); end
    n_checks++; if (cdbTag !== 3'd3) begin n_fails++; $display("FAIL idle_tag_hold: got %0d want 3", cdbTag); end
    n_checks++; if (cdbData !== 16'h1234) begin n_fails++; $display("FAIL idle_data_hold: got %h want 1234", cdbData); end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_seq [4];
    logic [2:0] prev;
    exp_seq[0] = 3'b001; exp_seq[1] = 3'b010; exp_seq[2] = 3'b100; exp_seq[3] = 3'b001;
    do_reset();
    req  = 3'b111;
    prev = 3'b000;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_checks++;
      if (gnt !== exp_seq[c]) begin
        n_fails++; $display("FAIL rr_grant_%0d: got %b want %b", c, gnt, exp_seq[c]);
      end
      // A unit drops req in the cycle after its grant, then re-raises it.
      req  = 3'b111 & ~prev;
      prev = exp_seq[c];
    end
    req = 3'b000;
  endtask

  task automatic test_fairness();
    do_reset();
    req = 3'b100;
    tick();
    n_checks++; if (gnt !== 3'b100) begin n_fails++; $display("FAIL fair_first: got %b want 100", gnt); end
    req = 3'b101;
    tick();
    n_checks++; if (gnt !== 3'b001) begin n_fails++; $display("FAIL fair_fu0: got %b want 001", gnt); end
    tick();
    n_checks++; if (gnt !== 3'b100) begin n_fails++; $display("FAIL fair_fu2: got %b want 100", gnt); end
    req = 3'b000;
  endtask

  task automatic test_stall();
    do_reset();
    req = 3'b100; tag2 = 3'd4; rd2 = 3'd2; data2 = 16'hBEEF;
    tag1 = 3'd6; rd1 = 3'd1; data1 = 16'h0F0F;
    tick();
    req = 3'b010; cdbStall = 1'b1;
    #1;
    n_checks++; if (rfWren !== 1'b0) begin n_fails++; $display("FAIL stall_rfwren_first: got %b want 0", rfWren); end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++; if (cdbTag !== 3'd4) begin n_fails++; $display("FAIL stall_tag_%0d: got %0d want 4", i, cdbTag); end
      n_checks++; if (cdbValid !== 1'b1) begin n_fails++; $display("FAIL stall_valid_%0d: got %b want 1", i, cdbValid); end
      n_checks++; if (gnt !== 3'b000) begin n_fails++; $display("FAIL stall_gnt_%0d: got %b want 000", i, gnt); end
      n_checks++; if (rfWren !== 1'b0) begin n_fails++; $display("FAIL stall_rfwren_%0d: got %b want 0", i, rfWren); end
    end
    tick();
    cdbStall = 1'b0;
    #1;
    n_checks++; if (rfWren !== 1'b1) begin n_fails++; $display("FAIL release_rfwren: got %b want 1", rfWren); end
    n_checks++; if (gnt !== 3'b000) begin n_fails++; $display("FAIL release_gnt: got %b want 000", gnt); end
    n_checks++; if (rfDataW !== 16'hBEEF) begin n_fails++; $display("FAIL release_data: got %h want beef", rfDataW); end
    tick();
    n_checks++; if (gnt !== 3'b010) begin n_fails++; $display("FAIL after_stall_gnt: got %b want 010", gnt); end
    n_checks++; if (cdbTag !== 3'd6) begin n_fails++; $display("FAIL after_stall_tag: got %0d want 6", cdbTag); end
    req = 3'b000;
    tick();
    n_checks++; if (rfWren !== 1'b0) begin n_fails++; $display("FAIL after_stall_idle: got %b want 0", rfWren); end
  endtask

  task automatic test_reset_mid_stall();
    logic [2:0] exp_seq [3];
    exp_seq[0] = 3'b001; exp_seq[1] = 3'b010; exp_seq[2] = 3'b100;
    do_reset();
    req = 3'b010;
    tick();
    req = 3'b000; cdbStall = 1'b1;
    tick();
    n_checks++; if (cdbValid !== 1'b1) begin n_fails++; $display("FAIL midstall_held: got %b want 1", cdbValid); end
    CLR = 1'b1; req = 3'b110;
    tick();
    CLR = 1'b0; cdbStall = 1'b0; req = 3'b111;
    #1;
    n_checks++; if (cdbValid !== 1'b0) begin n_fails++; $display("FAIL midstall_valid: got %b want 0", cdbValid); end
    n_checks++; if (gnt !== 3'b000) begin n_fails++; $display("FAIL midstall_gnt: got %b want 000", gnt); end
    n_checks++; if (rfWren !== 1'b0) begin n_fails++; $display("FAIL midstall_discard: got %b want 0", rfWren); end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if (gnt !== exp_seq[c]) begin
        n_fails++; $display("FAIL midstall_order_%0d: got %b want %b", c, gnt, exp_seq[c]);
      end
    end
    req = 3'b000;
  endtask

  task automatic randomize_fu(input int i);
    case (i)
      0: begin tag0 = 3'($urandom); rd0 = 3'($urandom); data0 = 16'($urandom); end
      1: begin tag1 = 3'($urandom); rd1 = 3'($urandom); data1 = 16'($urandom); end
      default: begin tag2 = 3'($urandom); rd2 = 3'($urandom); data2 = 16'($urandom); end
    endcase
  endtask

  task automatic test_random();
    logic [48:0] exp_v, got_v;
    logic [2:0]  prev_gnt;
    do_reset();
    req = 3'b000;
    prev_gnt = 3'b000;
    for (int c = 0; c < 600; c++) begin
      CLR      = ($urandom_range(0, 49) == 0);
      cdbStall = ($urandom_range(0, 3) == 0);
      #1;
      tick();
      exp_v = {m_gnt, m_valid, m_tag, m_data, m_rd,
               m_valid & ~cdbStall, m_rd, 3'b000, m_data};
      got_v = {gnt, cdbValid, cdbTag, cdbData, cdbRd, rfWren, rfNumW, rfDepW, rfDataW};
      n_checks++;
      if (got_v !== exp_v) begin
        n_fails++; $display("FAIL random_bus_%0d: got %h want %h", c, got_v, exp_v);
      end
      n_checks++;
      if (!$onehot0(gnt) || ((gnt & prev_gnt) != 3'b000)) begin
        n_fails++; $display("FAIL random_gnt_pulse_%0d: got %b after %b", c, gnt, prev_gnt);
      end
      prev_gnt = gnt;
      for (int i = 0; i < 3; i++) begin
        if (m_gnt[i]) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 2) == 0) begin
          randomize_fu(i);
          req[i] = 1'b1;
        end
      end
    end
    CLR = 1'b0; cdbStall = 1'b0; req = 3'b000;
  endtask

  initial begin
    CLR = 1'b1; req = 3'b000; cdbStall = 1'b0;
    tag0 = '0; tag1 = '0; tag2 = '0;
    rd0 = '0; rd1 = '0; rd2 = '0;
    data0 = '0; data1 = '0; data2 = '0;
    m_ptr = 0; m_gnt = '0; m_valid = 1'b0; m_tag = '0; m_data = '0; m_rd = '0;
    test_reset();
    test_single();
    test_idle_gap();
    test_round_robin();
    test_fairness();
    test_stall();
    test_reset_mid_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter TAGW, default 3, meaning the reservation-station tag width; it matches the register file dep width.
REQ-002 SHALL have parameter DATAW, default 16, meaning the result data width; it matches the register file data width.
REQ-003 SHALL have port CLK, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port CLR, input, 1, reset; it is synchronous and active-high.
REQ-005 SHALL have port req, input, 3, per-functional-unit (FU0..FU2) result-ready request; the FU holds it until it sees gnt.
REQ-006 SHALL have ports tag0/tag1/tag2, input, TAGW each, the producing tag of each FU; tag 0 is reserved.
REQ-007 SHALL have ports rd0/rd1/rd2, input, 3 each, the destination register number of each FU.
REQ-008 SHALL have ports data0/data1/data2, input, DATAW each, the result value of each FU.
REQ-009 SHALL have port cdbStall, input, 1, a downstream stall that freezes the bus.
REQ-010 SHALL have port gnt, output, 3, a one-hot single-cycle grant pulse.
REQ-011 SHALL have port cdbValid, output, 1, which is high when the bus holds a result.
REQ-012 SHALL have ports cdbTag (TAGW), cdbData (DATAW) and cdbRd (3), output, the broadcast result.
REQ-013 SHALL have ports rfWren (1), rfNumW (3), rfDepW (TAGW) and rfDataW (DATAW), output, which drive the register-file write port.

Function
REQ-014 SHALL keep a round-robin pointer ptr in the range 0..2; the priority order is ptr, ptr+1, ptr+2 (mod 3).
REQ-015 SHALL define the eligible requesters as req & ~gnt, so that the FU granted in the current cycle is masked at the next edge.
REQ-016 SHALL, at each edge with CLR=0 and cdbStall=0 and any eligible requester:
- choose the winner w by round-robin;
- register tag_w, rd_w and data_w onto the bus;
- set cdbValid=1 and gnt=onehot(w);
- set ptr=(w+1) mod 3.
REQ-017 SHALL, at an edge with CLR=0, cdbStall=0 and no eligible requester, set cdbValid=0 and gnt=0; ptr, cdbTag, cdbData and cdbRd hold.
REQ-018 SHALL, at an edge with cdbStall=1, hold cdbValid, cdbTag, cdbData, cdbRd and ptr, and force gnt=0; no new grant is made.
REQ-019 SHALL give a latency of one edge from request sampled to broadcast visible; gnt and the new bus contents appear in the same cycle.
REQ-020 SHALL count a broadcast as consumed in every cycle with cdbValid=1 and cdbStall=0; a stalled broadcast is consumed exactly once, in the cycle after stall release.
REQ-021 SHALL drive rfWren = cdbValid & ~cdbStall, rfNumW = cdbRd, rfDataW = cdbData and rfDepW = 0 (clears the dependency), combinationally from the registers.
REQ-022 SHALL support back-to-back broadcasts every cycle when different FUs request; the same FU is granted at most every other cycle.
REQ-023 SHALL broadcast a request carrying tag 0 unchanged; checking tags is the FU's responsibility.
REQ-024 SHALL make gnt a registered single-cycle pulse; it never stays high for two consecutive cycles.

Reset
REQ-025 SHALL, when CLR=1 at an edge, set ptr=0, gnt=0, cdbValid=0, cdbTag=0, cdbRd=0 and cdbData=0; this overrides stall and requests.
REQ-026 SHALL hold rfWren=0 in the cycle after reset.
REQ-027 SHALL discard a broadcast in flight when reset is applied mid-stall, without it ever being consumed.

Structure
REQ-028 SHALL place TAGW, DATAW, NFU=3 and TAG_NONE=0 in the shared package tomasulo_pkg.
REQ-029 SHALL place the rotate-priority selection in one combinational sub-module rr_picker, with inputs eligible[2:0] and ptr, and outputs onehot and idx.
REQ-030 SHALL connect the rf* outputs directly to the register-file wren, numW, depW and dataW inputs.

Verification
REQ-031 SHALL cover single request: req=001, tag0=3, rd0=5, data0=16'h1234 -> next cycle gnt=001, cdbValid=1, cdbTag=3, rfWren=1, rfNumW=5, rfDataW=16'h1234, rfDepW=0.
REQ-032 SHALL cover all requesting continuously: req=111 held, each FU dropping req the cycle after its gnt and re-raising it the next -> grants are 001, 010, 100, 001 on consecutive cycles.
REQ-033 SHALL cover pointer fairness: FU2 is granted (ptr becomes 0), then req=101 -> FU0 is granted first, then FU2.
REQ-034 SHALL cover stall: broadcast of tag 4 with cdbStall=1 for 3 cycles and req=010 pending -> bus holds tag 4, gnt=0 and rfWren=0 throughout; on release rfWren=1 for one cycle, then FU1 is granted.
REQ-035 SHALL cover reset mid-stall: CLR=1 for one edge while stalled with cdbValid=1 -> cdbValid=0, ptr=0, gnt=0; the next grant follows order 0, 1, 2.
REQ-036 SHALL cover the idle gap: req=000 after a broadcast -> cdbValid=0 and rfWren=0, while cdbTag and cdbData hold their previous values.
